// File: rtl/win_sum_fifo.sv
// First-word-fall-through FIFO for signed window sums; a written word shows on rd_data one edge after the write.
// Consumer drains through a valid/ready handshake; when full, a write is accepted only alongside a pop, otherwise it is dropped and overflow latches.
module win_sum_fifo #(
    parameter int DATA_W   = 38,
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int AF_LEVEL = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              overflow,
    input  logic              clr_ovf
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push;
    logic              pop;

    assign empty       = (count == '0);
    assign full        = (count == (AW+1)'(DEPTH));
    assign almost_full = (count >= (AW+1)'(AF_LEVEL));
    assign rd_valid    = ~empty;
    assign rd_data     = rd_valid ? mem[rd_ptr] : '0;

    // A write into a full FIFO is still taken when the head leaves in the same cycle.
    assign pop  = rd_valid & rd_ready;
    assign push = wr_en & (~full | pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_en & ~push)  overflow <= 1'b1;
            else if (clr_ovf)   overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: tb/tb_win_sum_fifo.sv
// Directed bench for win_sum_fifo: a driver keeps an occupancy/overflow model and queues expected words;
// a negedge monitor pops the queue on each handshake and compares rd_data.
module tb_win_sum_fifo;
    localparam int DW    = 38;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int AF    = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic          rd_ready = 1'b0;
    logic          clr_ovf = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid, full, empty, almost_full, overflow;
    logic [AW:0]   count;

    always #5 clk = ~clk;

    win_sum_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .AW(AW), .AF_LEVEL(AF)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
        .count(count), .full(full), .empty(empty), .almost_full(almost_full),
        .overflow(overflow), .clr_ovf(clr_ovf)
    );

    int            nvec = 0;
    int            nerr = 0;
    logic [DW-1:0] exp_q[$];
    int            mcnt = 0;
    logic          movf = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted read must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL rd_unexpected: got %0h expected no read", rd_data);
            end else begin
                chk("rd_data", 64'(rd_data), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic chk_state();
        chk("count",       64'(count),       64'(mcnt));
        chk("empty",       64'(empty),       64'(mcnt == 0));
        chk("full",        64'(full),        64'(mcnt == DEPTH));
        chk("almost_full", 64'(almost_full), 64'(mcnt >= AF));
        chk("overflow",    64'(overflow),    64'(movf));
        chk("rd_valid",    64'(rd_valid),    64'(mcnt != 0));
        if (mcnt == 0) chk("rd_data_idle", 64'(rd_data), 64'd0);
    endtask

    // One clock of stimulus; the model decides push/pop from its own occupancy.
    task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        logic pu, po;
        wr_en = w; wr_data = d; rd_ready = r; clr_ovf = c;
        po = r && (mcnt != 0);
        pu = w && ((mcnt != DEPTH) || po);
        if (pu) exp_q.push_back(d);
        if (w && !pu) movf = 1'b1;
        else if (c)   movf = 1'b0;
        mcnt = mcnt + int'(pu) - int'(po);
        @(posedge clk); #1;
        wr_en = 1'b0; rd_ready = 1'b0; clr_ovf = 1'b0;
        chk_state();
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH && mcnt != 0; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_en = 1'b0; rd_ready = 1'b0; clr_ovf = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        mcnt = 0;
        movf = 1'b0;
        chk_state();
    endtask

    initial begin
        logic [DW-1:0] v;
        logic          w5, r5;
        int            nxt;

        do_reset();

        // 1: three words, then read them back in order
        v = -38'sd5;          cyc(1'b1, v, 1'b0, 1'b0);
        v = 38'd100;          cyc(1'b1, v, 1'b0, 1'b0);
        v = 38'h1F_FFFF_FFFF; cyc(1'b1, v, 1'b0, 1'b0);
        chk("t1_count3", 64'(count), 64'd3);
        drain();
        chk("t1_empty", 64'(empty), 64'd1);

        // 2: fill to 16 with no reads, 17th write dropped
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, DW'(1000 + i), 1'b0, 1'b0);
        cyc(1'b1, DW'(7), 1'b0, 1'b0);
        chk("t2_ovf",  64'(overflow), 64'd1);
        chk("t2_head", 64'(rd_data),  64'd1000);

        // 3: write and pop together while full; new word comes out last
        cyc(1'b1, DW'('hABC), 1'b1, 1'b0);
        chk("t3_count16", 64'(count), 64'd16);
        // drop coinciding with clr_ovf keeps overflow set
        cyc(1'b1, DW'('h55), 1'b0, 1'b1);
        chk("t3_setwins", 64'(overflow), 64'd1);
        for (int i = 0; i < DEPTH - 1; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        chk("t3_last", 64'(rd_data), 64'hABC);
        drain();

        // 4: empty FIFO, write and ready together -> write only
        v = '1;
        cyc(1'b1, v, 1'b1, 1'b0);
        chk("t4_valid", 64'(rd_valid), 64'd1);
        chk("t4_head",  64'(rd_data),  64'h3F_FFFF_FFFF);
        chk("t4_count", 64'(count),    64'd1);
        drain();
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("t4_clr", 64'(overflow), 64'd0);

        // 5: stream 0..39 with random read gaps across pointer wrap
        nxt = 0;
        for (int k = 0; k < 3000 && (nxt < 40 || mcnt != 0); k++) begin
            r5 = ($urandom_range(0, 2) != 0);
            w5 = (nxt < 40) && (mcnt < DEPTH) && ($urandom_range(0, 3) != 0);
            cyc(w5, DW'(nxt), r5, 1'b0);
            if (w5) nxt++;
        end
        chk("t5_all_sent", 64'(nxt), 64'd40);
        chk("t5_ovf", 64'(overflow), 64'd0);

        // 6: count 7 with overflow set, then reset
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, DW'(200 + i), 1'b0, 1'b0);
        cyc(1'b1, DW'(9), 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        chk("t6_count7", 64'(count),    64'd7);
        chk("t6_ovf1",   64'(overflow), 64'd1);
        do_reset();
        chk("t6_rst_count", 64'(count),    64'd0);
        chk("t6_rst_ovf",   64'(overflow), 64'd0);
        chk("t6_rst_data",  64'(rd_data),  64'd0);

        chk("scoreboard_left", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
